// File: rtl/pipe_mux_n.sv
// pipe_mux_n: N-to-1 valid/ready selector into a registered two-entry skid buffer.
// in_ready depends only on sel and buffer occupancy, never on out_ready.
module pipe_mux_n #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_INPUTS = 4,
   localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_INPUTS-1:0]            in_valid,
   output logic [NUM_INPUTS-1:0]            in_ready,
   input  logic [SEL_W-1:0]                 sel,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             sel_err
);
   localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2;
   localparam logic [SEL_W:0] SEL_LIM = NUM_INPUTS[SEL_W:0];

   logic [1:0] state;
   logic [DATA_WIDTH-1:0] skid, din;
   logic sel_ok, accept, drain;

   assign sel_ok = {1'b0, sel} < SEL_LIM;
   assign accept = |(in_valid & in_ready);
   assign drain = out_valid && out_ready;
   assign out_valid = state != EMPTY;

   genvar i;
   generate
      for (i = 0; i < NUM_INPUTS; i++) begin : g_rdy
         assign in_ready[i] = sel_ok && sel == SEL_W'(i) && state != TWO && !rst;
      end
   endgenerate

   always_comb begin
      din = '0;
      for (int j = 0; j < NUM_INPUTS; j++)
         if (sel == SEL_W'(j)) din = in_data[j*DATA_WIDTH +: DATA_WIDTH];
   end

   always_ff @(posedge clk)
      if (rst) begin
         state <= EMPTY;
         out_data <= '0;
         skid <= '0;
         sel_err <= 1'b0;
      end else begin
         sel_err <= !sel_ok && |in_valid;
         case (state)
            EMPTY: if (accept) begin
               state <= ONE;
               out_data <= din;
            end
            ONE: if (accept && drain) out_data <= din;
               else if (accept) begin
                  state <= TWO;
                  skid <= din;
               end else if (drain) state <= EMPTY;
            TWO: if (drain) begin
               state <= ONE;
               out_data <= skid;
            end
            default: state <= EMPTY;
         endcase
      end
endmodule

// File: tb/tb_pipe_mux_n.sv
// tb_pipe_mux_n: directed vector table on a 32x4 instance, out-of-range select on 8x3,
// then random traffic on four configurations against an occupancy/FIFO reference model.
module tb_pipe_mux_n;
   logic clk = 1'b0;
   logic rst;
   logic [1023:0] din [4];
   logic [15:0] vld [4];
   logic [3:0] sel [4];
   logic ordy [4];

   logic [3:0] rdy_a;
   logic [2:0] rdy_b;
   logic [1:0] rdy_c;
   logic [15:0] rdy_d;
   logic [31:0] od_a;
   logic [7:0] od_b, od_c;
   logic [63:0] od_d;
   logic ov_a, ov_b, ov_c, ov_d, se_a, se_b, se_c, se_d;

   logic [15:0] rdy [4];
   logic [63:0] od [4];
   logic ov [4], se [4];

   logic [63:0] mq [4][2];
   int cnt [4];
   logic exp_err [4];
   int n_chk = 0, n_fail = 0;

   typedef struct {
      logic r; logic [1:0] s; logic [3:0] v; logic [31:0] d; logic o;
      logic c; logic [3:0] er; logic eov; logic [31:0] eod;
   } vec_t;
   vec_t tbl [20];

   pipe_mux_n #(.DATA_WIDTH(32), .NUM_INPUTS(4)) dut_a (.clk(clk), .rst(rst), .in_data(din[0][127:0]),
      .in_valid(vld[0][3:0]), .in_ready(rdy_a), .sel(sel[0][1:0]), .out_data(od_a), .out_valid(ov_a),
      .out_ready(ordy[0]), .sel_err(se_a));
   pipe_mux_n #(.DATA_WIDTH(8), .NUM_INPUTS(3)) dut_b (.clk(clk), .rst(rst), .in_data(din[1][23:0]),
      .in_valid(vld[1][2:0]), .in_ready(rdy_b), .sel(sel[1][1:0]), .out_data(od_b), .out_valid(ov_b),
      .out_ready(ordy[1]), .sel_err(se_b));
   pipe_mux_n #(.DATA_WIDTH(8), .NUM_INPUTS(2)) dut_c (.clk(clk), .rst(rst), .in_data(din[2][15:0]),
      .in_valid(vld[2][1:0]), .in_ready(rdy_c), .sel(sel[2][0:0]), .out_data(od_c), .out_valid(ov_c),
      .out_ready(ordy[2]), .sel_err(se_c));
   pipe_mux_n #(.DATA_WIDTH(64), .NUM_INPUTS(16)) dut_d (.clk(clk), .rst(rst), .in_data(din[3]),
      .in_valid(vld[3]), .in_ready(rdy_d), .sel(sel[3]), .out_data(od_d), .out_valid(ov_d),
      .out_ready(ordy[3]), .sel_err(se_d));

   always_comb begin
      rdy[0] = 16'(rdy_a); rdy[1] = 16'(rdy_b); rdy[2] = 16'(rdy_c); rdy[3] = rdy_d;
      od[0] = 64'(od_a); od[1] = 64'(od_b); od[2] = 64'(od_c); od[3] = od_d;
      ov[0] = ov_a; ov[1] = ov_b; ov[2] = ov_c; ov[3] = ov_d;
      se[0] = se_a; se[1] = se_b; se[2] = se_c; se[3] = se_d;
   end

   always #5 clk = ~clk;

   function automatic int nn(int k);
      return k == 0 ? 4 : k == 1 ? 3 : k == 2 ? 2 : 16;
   endfunction
   function automatic int ww(int k);
      return k == 0 ? 32 : k == 3 ? 64 : 8;
   endfunction
   function automatic int sw(int k);
      return k == 2 ? 1 : k == 3 ? 4 : 2;
   endfunction
   function automatic logic [63:0] wmask(int k);
      return ww(k) == 64 ? '1 : (64'd1 << ww(k)) - 64'd1;
   endfunction

   // Reference: a FIFO of at most two beats; accept when selected, in range and not full.
   always @(posedge clk)
      for (int k = 0; k < 4; k++) begin
         if (rst) begin
            cnt[k] = 0;
            exp_err[k] = 1'b0;
         end else begin
            automatic int s = int'(sel[k]);
            automatic bit in_rng = s < nn(k);
            automatic bit a = in_rng && vld[k][s] && cnt[k] < 2;
            automatic bit d = cnt[k] > 0 && ordy[k];
            automatic logic [63:0] v = 64'(din[k] >> (s * ww(k))) & wmask(k);
            exp_err[k] = !in_rng && ((int'(vld[k]) & ((1 << nn(k)) - 1)) != 0);
            if (d) begin
               mq[k][0] = mq[k][1];
               cnt[k] = cnt[k] - 1;
            end
            if (a) begin
               mq[k][cnt[k]] = v;
               cnt[k] = cnt[k] + 1;
            end
         end
      end

   function automatic logic [15:0] exp_rdy(int k);
      return (!rst && cnt[k] < 2 && int'(sel[k]) < nn(k)) ? (16'd1 << sel[k]) : 16'd0;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_model(input int k);
      chk($sformatf("k%0d ready", k), 64'(rdy[k]), 64'(exp_rdy(k)));
      chk($sformatf("k%0d valid", k), 64'(ov[k]), 64'(cnt[k] > 0));
      if (cnt[k] > 0) chk($sformatf("k%0d data", k), od[k], mq[k][0]);
      chk($sformatf("k%0d sel_err", k), 64'(se[k]), 64'(exp_err[k]));
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         din[k] = '0; vld[k] = '0; sel[k] = '0; ordy[k] = 1'b1;
      end
      tbl[0]  = '{1'b1, 2'd2, 4'b0100, 32'h99, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 2'd2, 4'b0100, 32'h11, 1'b1, 1'b1, 4'b0100, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 2'd2, 4'b0100, 32'h22, 1'b1, 1'b1, 4'b0100, 1'b1, 32'h11};
      tbl[3]  = '{1'b0, 2'd2, 4'b0100, 32'h33, 1'b1, 1'b1, 4'b0100, 1'b1, 32'h22};
      tbl[4]  = '{1'b0, 2'd1, 4'b0000, 32'h00, 1'b1, 1'b1, 4'b0010, 1'b1, 32'h33};
      tbl[5]  = '{1'b0, 2'd1, 4'b0010, 32'hA0, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h33};
      tbl[6]  = '{1'b0, 2'd1, 4'b0010, 32'hA1, 1'b0, 1'b1, 4'b0010, 1'b1, 32'hA0};
      tbl[7]  = '{1'b0, 2'd1, 4'b0010, 32'hA2, 1'b0, 1'b1, 4'b0000, 1'b1, 32'hA0};
      tbl[8]  = '{1'b0, 2'd1, 4'b0010, 32'hA2, 1'b1, 1'b1, 4'b0000, 1'b1, 32'hA0};
      tbl[9]  = '{1'b0, 2'd1, 4'b0010, 32'hA2, 1'b1, 1'b1, 4'b0010, 1'b1, 32'hA1};
      tbl[10] = '{1'b0, 2'd1, 4'b0000, 32'h00, 1'b1, 1'b1, 4'b0010, 1'b1, 32'hA2};
      tbl[11] = '{1'b0, 2'd0, 4'b0001, 32'h05, 1'b0, 1'b1, 4'b0001, 1'b0, 32'hA2};
      tbl[12] = '{1'b0, 2'd3, 4'b1000, 32'h09, 1'b0, 1'b1, 4'b1000, 1'b1, 32'h05};
      tbl[13] = '{1'b0, 2'd3, 4'b0000, 32'h00, 1'b0, 1'b1, 4'b0000, 1'b1, 32'h05};
      tbl[14] = '{1'b0, 2'd0, 4'b0001, 32'h77, 1'b1, 1'b1, 4'b0000, 1'b1, 32'h05};
      tbl[15] = '{1'b0, 2'd0, 4'b0000, 32'h00, 1'b0, 1'b1, 4'b0001, 1'b1, 32'h09};
      tbl[16] = '{1'b0, 2'd2, 4'b0100, 32'hC1, 1'b0, 1'b1, 4'b0100, 1'b1, 32'h09};
      tbl[17] = '{1'b1, 2'd2, 4'b0100, 32'hC2, 1'b0, 1'b1, 4'b0000, 1'b1, 32'h09};
      tbl[18] = '{1'b0, 2'd2, 4'b0000, 32'h00, 1'b1, 1'b1, 4'b0100, 1'b0, 32'h00};
      tbl[19] = '{1'b0, 2'd2, 4'b0000, 32'h00, 1'b1, 1'b1, 4'b0100, 1'b0, 32'h00};

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         rst = tbl[i].r;
         sel[0] = 4'(tbl[i].s);
         vld[0] = 16'(tbl[i].v);
         ordy[0] = tbl[i].o;
         for (int j = 0; j < 32; j++) din[0][j*32 +: 32] = $urandom;
         din[0][int'(tbl[i].s)*32 +: 32] = tbl[i].d;
         #1;
         chk($sformatf("vec%0d ready", i), 64'(rdy[0]), 64'(tbl[i].er));
         if (tbl[i].c) begin
            chk($sformatf("vec%0d valid", i), 64'(ov[0]), 64'(tbl[i].eov));
            chk($sformatf("vec%0d data", i), od[0], 64'(tbl[i].eod));
         end
      end

      // Out-of-range select on the three-channel instance.
      @(negedge clk); sel[1] = 4'd3; vld[1] = 16'h7; #1;
      chk("oor ready", 64'(rdy[1]), 64'h0);
      @(negedge clk); vld[1] = 16'h0; #1;
      chk("oor err pulse", 64'(se[1]), 64'h1);
      chk("oor ready idle", 64'(rdy[1]), 64'h0);
      @(negedge clk); vld[1] = 16'h2; #1;
      chk("oor err clear", 64'(se[1]), 64'h0);
      @(negedge clk); sel[1] = 4'd0; vld[1] = 16'h1; din[1][7:0] = 8'h5A; #1;
      chk("oor err pulse2", 64'(se[1]), 64'h1);
      chk("oor ready ch0", 64'(rdy[1]), 64'h1);
      @(negedge clk); vld[1] = 16'h0; #1;
      chk("oor err clear2", 64'(se[1]), 64'h0);
      chk("oor valid", 64'(ov[1]), 64'h1);
      chk("oor data", od[1], 64'h5A);

      for (int c = 0; c < 4000; c++) begin
         automatic int bp = (c / 500) % 3 == 0 ? 25 : (c / 500) % 3 == 1 ? 60 : 90;
         @(negedge clk);
         rst = $urandom_range(0, 299) == 0;
         for (int k = 0; k < 4; k++) begin
            sel[k] = 4'($urandom_range(0, (1 << sw(k)) - 1));
            vld[k] = 16'($urandom);
            ordy[k] = $urandom_range(0, 99) < bp;
            for (int j = 0; j < 32; j++) din[k][j*32 +: 32] = $urandom;
         end
         #1;
         for (int k = 0; k < 4; k++) check_model(k);
      end

      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         rst = 1'b0;
         for (int k = 0; k < 4; k++) begin
            vld[k] = '0;
            ordy[k] = 1'b1;
         end
         #1;
         for (int k = 0; k < 4; k++) check_model(k);
      end
      for (int k = 0; k < 4; k++) chk($sformatf("k%0d drained", k), 64'(ov[k]), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_mux_n.md
# pipe_mux_n

Parametrised N-to-1 data selector with a valid/ready handshake on every input and on the output, plus a two-entry skid buffer. Full throughput with the output ready path fully registered. It replaces fixed-width, fixed-count combinational muxes wherever a selected source must cross a pipeline boundary. Typical uses are result selection into writeback and the load/ALU/PC+4 merge feeding a register stage. Data order is preserved, and no beat is lost or duplicated under backpressure.

## Interface
- DATA_WIDTH, 32, width of each data channel
- NUM_INPUTS, 4, number of input channels (2..16); select width is $clog2(NUM_INPUTS), minimum 1
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  NUM_INPUTS*DATA_WIDTH  packed channels; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  in  NUM_INPUTS  per-channel valid
- in_ready  out  NUM_INPUTS  per-channel ready; at most one bit high
- sel  in  $clog2(NUM_INPUTS)  channel select, evaluated every cycle
- out_data  out  DATA_WIDTH  registered output data
- out_valid  out  1  registered output valid
- out_ready  in  1  downstream ready
- sel_err  out  1  registered one-cycle pulse: out-of-range sel while any in_valid high

## Operation
- Storage: main register (drives out_data) and skid register. States: EMPTY, ONE (main valid), TWO (main and skid valid).
- in_ready[i] = (i == sel) && (sel < NUM_INPUTS) && (state != TWO) && !rst. This is combinational from sel; there is no path from out_ready.
- Accept occurs when in_valid[sel] && in_ready[sel]. Drain occurs when out_valid && out_ready.
- State transitions:
  - EMPTY + accept → ONE; main ← selected data.
  - ONE + accept, no drain → TWO; skid ← data.
  - ONE + accept + drain → ONE; main ← new data.
  - ONE + drain, no accept → EMPTY.
  - TWO + drain → ONE; main ← skid. No accept is possible in TWO.
  - Any other combination holds the current state.
- out_valid = (state != EMPTY). out_data = main.
- Changing sel never alters beats already buffered. It only governs which channel is accepted next.
- Out-of-range sel (possible when NUM_INPUTS is not a power of two): all in_ready low, nothing accepted. sel_err is high the following cycle if any in_valid bit was high.
- Non-selected channels always see in_ready = 0. Their valid and data are ignored.
- out_data holds its last value while out_valid is low; downstream must not sample it then.

## Timing
- Reset values: out_valid 0, out_data 0, sel_err 0, state EMPTY, skid 0. in_ready is all zeros while rst is high.
- Reset mid-operation: both entries are flushed, and buffered beats are discarded without being presented.
- Latency: a beat accepted at edge N is presented (out_valid = 1) from cycle N+1.
- Throughput: one beat per cycle while out_ready stays high.
- Backpressure: with out_ready low, at most two beats are absorbed, then in_ready[sel] falls in the cycle after the second accept.
- Recovery: in_ready[sel] re-asserts in the cycle after the first drain from TWO.
- Reset and accept on the same edge: reset wins and nothing is stored.
- Stability rule: out_valid, once high, stays high with out_data stable until a drain occurs.

## Test plan
- Streaming: NUM_INPUTS=4, sel=2, in_valid[2] high with data 0x11, 0x22, 0x33 on consecutive cycles, out_ready held high → out_data 0x11, 0x22, 0x33 on consecutive cycles, first one cycle after its accept. in_ready must equal 4'b0100 throughout.
- Backpressure: out_ready low, channel 1 sends 0xA0, 0xA1, 0xA2 → 0xA0 and 0xA1 accepted, in_ready[1] drops, 0xA2 held by the source. Raising out_ready then yields 0xA0, 0xA1, 0xA2 in order with no gap after the first drain.
- Select switch: sel=0 sends 0x5, then sel=3 sends 0x9 while 0x5 is still stalled → output order 0x5 then 0x9, with no corruption of the buffered 0x5.
- Out-of-range select: NUM_INPUTS=3, sel=3, in_valid=3'b111 → in_ready=0, nothing accepted, sel_err pulses high for one cycle per offending cycle.
- Reset while TWO: fill both entries, assert rst one cycle → out_valid=0 next cycle, and no stale beat appears after reset deasserts.
- Width/count sweep: DATA_WIDTH=8/NUM_INPUTS=2 and DATA_WIDTH=64/NUM_INPUTS=16 with random valid/ready and sel → scoreboard shows every accepted beat delivered exactly once, in order.
